// File: rtl/step_dir_driver_if.sv
// Bundles the step generator inputs and the power stage outputs of step_dir_driver.
// slave = driver stage, master = whoever drives the raw step/dir and reads the pins.
interface step_dir_driver_if #(
    parameter int POS_W = 32
);
    logic             step_in;
    logic             dir_in;
    logic             drv_enable;
    logic             limit_n;
    logic             clear_fault;
    logic             step_out;
    logic             dir_out;
    logic             drv_en_n;
    logic [POS_W-1:0] position;
    logic             busy;
    logic             step_dropped;
    logic             limit_hit;

    modport master (
        output step_in, dir_in, drv_enable, limit_n, clear_fault,
        input  step_out, dir_out, drv_en_n, position, busy, step_dropped, limit_hit
    );

    modport slave (
        input  step_in, dir_in, drv_enable, limit_n, clear_fault,
        output step_out, dir_out, drv_en_n, position, busy, step_dropped, limit_hit
    );
endinterface

// File: rtl/step_dir_driver.sv
// STEP/DIR output stage: DIR setup, min pulse widths, endstop gating, position counter.
// Optional STEPDRV_HOME_ZERO_EN: rising edge of the synced endstop zeroes the position.
module step_dir_driver #(
    parameter int DIR_SETUP_CYC = 250,
    parameter int STEP_HIGH_CYC = 100,
    parameter int STEP_LOW_CYC  = 100,
    parameter int POS_W         = 32
) (
    input  logic              CLK_50MHZ,
    input  logic              rst_n,
    step_dir_driver_if.slave  bus
);
    localparam int CNT_MAX_A = (DIR_SETUP_CYC > STEP_HIGH_CYC) ? DIR_SETUP_CYC : STEP_HIGH_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > STEP_LOW_CYC) ? CNT_MAX_A : STEP_LOW_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIR_LOAD  = CNT_W'(DIR_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(STEP_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(STEP_LOW_CYC - 1);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

    typedef enum logic [1:0] {IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q;
    logic             pend_q, pend_d;
    logic             pend_dir_q, pend_dir_d;
    logic [1:0]       lim_sync_q;
    logic             step_out_q, step_out_d;
    logic             dir_out_q, dir_out_d;
    logic             drv_en_n_q;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dropped_q, dropped_d;
    logic             limhit_q, limhit_d;
`ifdef STEPDRV_HOME_ZERO_EN
    logic             lim_prev_q;
`endif

    logic en;
    logic lim;
    logic step_edge;
    logic consume;
    logic pos_step;
    logic limit_set;
    logic drop_set;

    assign en        = bus.drv_enable;
    assign lim       = ~lim_sync_q[1];
    assign step_edge = bus.step_in & ~step_q;
    assign consume   = en & pend_q & (state_q == IDLE);

    // State register and all other storage
    always_ff @(posedge CLK_50MHZ) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            step_q     <= 1'b1;
            pend_q     <= 1'b0;
            pend_dir_q <= 1'b0;
            lim_sync_q <= 2'b11;
            step_out_q <= 1'b0;
            dir_out_q  <= 1'b0;
            drv_en_n_q <= 1'b1;
            pos_q      <= '0;
            dropped_q  <= 1'b0;
            limhit_q   <= 1'b0;
`ifdef STEPDRV_HOME_ZERO_EN
            lim_prev_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= bus.step_in;
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
            lim_sync_q <= {lim_sync_q[0], bus.limit_n};
            step_out_q <= step_out_d;
            dir_out_q  <= dir_out_d;
            drv_en_n_q <= ~bus.drv_enable;
            pos_q      <= pos_d;
            dropped_q  <= dropped_d;
            limhit_q   <= limhit_d;
`ifdef STEPDRV_HOME_ZERO_EN
            lim_prev_q <= lim;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_q && !(lim && !pend_dir_q)) begin
                        state_d = (pend_dir_q != dir_out_q) ? DIR_SETUP : PULSE_HIGH;
                    end
                end
                DIR_SETUP:  if (cnt_q == '0) state_d = PULSE_HIGH;
                PULSE_HIGH: if (cnt_q == '0) state_d = PULSE_LOW;
                PULSE_LOW:  if (cnt_q == '0) state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        step_out_d = step_out_q;
        dir_out_d  = dir_out_q;
        pos_step   = 1'b0;
        limit_set  = 1'b0;
        if (!en) begin
            step_out_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (consume) begin
                        if (lim && !pend_dir_q) begin
                            limit_set = 1'b1;
                        end else if (pend_dir_q != dir_out_q) begin
                            dir_out_d = pend_dir_q;
                            cnt_d     = DIR_LOAD;
                        end else begin
                            step_out_d = 1'b1;
                            pos_step   = 1'b1;
                            cnt_d      = HIGH_LOAD;
                        end
                    end
                end
                DIR_SETUP: begin
                    if (cnt_q == '0) begin
                        step_out_d = 1'b1;
                        pos_step   = 1'b1;
                        cnt_d      = HIGH_LOAD;
                    end
                end
                PULSE_HIGH: begin
                    if (cnt_q == '0) begin
                        step_out_d = 1'b0;
                        cnt_d      = LOW_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-deep step buffer; an edge is lost only if the slot is still occupied after this cycle
    always_comb begin
        pend_d     = pend_q & ~consume;
        pend_dir_d = pend_dir_q;
        drop_set   = 1'b0;
        if (!en) begin
            pend_d = 1'b0;
        end else if (step_edge) begin
            if (pend_q && !consume) begin
                drop_set = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pend_dir_d = bus.dir_in;
            end
        end
    end

    always_comb begin
        pos_d = pos_q;
        if (pos_step) begin
            pos_d = dir_out_q ? pos_q + POS_ONE : pos_q - POS_ONE;
        end
`ifdef STEPDRV_HOME_ZERO_EN
        if (lim && !lim_prev_q) begin
            pos_d = '0;
        end
`endif
    end

    always_comb begin
        dropped_d = drop_set  | (dropped_q & ~bus.clear_fault);
        limhit_d  = limit_set | (limhit_q  & ~bus.clear_fault);
    end

    assign bus.step_out     = step_out_q;
    assign bus.dir_out      = dir_out_q;
    assign bus.drv_en_n     = drv_en_n_q;
    assign bus.position     = pos_q;
    assign bus.busy         = (state_q != IDLE) | pend_q;
    assign bus.step_dropped = dropped_q;
    assign bus.limit_hit    = limhit_q;
endmodule

// File: tb/tb_step_dir_driver.sv
// Directed bench for step_dir_driver: expected pulses go into a scoreboard queue,
// a negedge monitor pops one entry per STEP rising edge and checks timing, DIR, position, width.
module tb_step_dir_driver;
    localparam int DIR_SETUP = 250;
    localparam int HIGH_W    = 100;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   exp_pos;

    typedef struct {
        int rise;
        bit dir;
        int pos;
        int width;
        bit dirchg;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   rise_cyc;
    int   dir_chg_cyc;
    logic prev_step;
    logic prev_dir;

    step_dir_driver_if #(.POS_W(32)) bus ();

    step_dir_driver dut (
        .CLK_50MHZ (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor
    initial begin
        prev_step   = 1'b0;
        prev_dir    = 1'b0;
        rise_cyc    = 0;
        dir_chg_cyc = 0;
        cur         = '{rise: 0, dir: 1'b0, pos: 0, width: 0, dirchg: 1'b0};
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dir_out !== prev_dir) begin
                dir_chg_cyc = cyc;
                check("dir_change_while_step_low", {63'd0, prev_step | bus.step_out}, 0);
            end
            if (bus.step_out && !prev_step) begin
                rise_cyc = cyc;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pulse: rise at cycle %0d, expected none", cyc);
                    cur = '{rise: cyc, dir: bus.dir_out, pos: 0, width: 0, dirchg: 1'b0};
                end else begin
                    cur = sb.pop_front();
                    $display("pulse: rise cycle %0d dir %0d position %0d", cyc, bus.dir_out,
                             $signed(bus.position));
                    check("rise_cycle", cyc, cur.rise);
                    check("rise_dir", {63'd0, bus.dir_out}, {63'd0, cur.dir});
                    check("rise_position", int'($signed(bus.position)), cur.pos);
                    if (cur.dirchg) check("dir_setup_gap", cyc - dir_chg_cyc, DIR_SETUP);
                end
            end
            if (!bus.step_out && prev_step && cur.width != 0) begin
                check("pulse_width", cyc - rise_cyc, cur.width);
            end
        end
        prev_step = bus.step_out;
        prev_dir  = bus.dir_out;
    end

    task automatic wait_cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_step(input bit d, output int n);
        @(posedge clk);
        #1;
        bus.step_in = 1'b1;
        bus.dir_in  = d;
        n = cyc;
        @(posedge clk);
        #1;
        bus.step_in = 1'b0;
    endtask

    task automatic step_exp(input bit d, input bit dirchg, input int width);
        int   n;
        exp_t e;
        do_step(d, n);
        exp_pos = d ? exp_pos + 1 : exp_pos - 1;
        e.rise   = n + 2 + (dirchg ? DIR_SETUP : 0);
        e.dir    = d;
        e.pos    = exp_pos;
        e.width  = width;
        e.dirchg = dirchg;
        sb.push_back(e);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1;
        bus.clear_fault = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_fault = 1'b0;
    endtask

    initial begin
        int   n;
        int   m;
        int   r;
        exp_t e;
        n_checks        = 0;
        n_pass          = 0;
        exp_pos         = 0;
        rst_n           = 1'b0;
        bus.step_in     = 1'b0;
        bus.dir_in      = 1'b0;
        bus.drv_enable  = 1'b0;
        bus.limit_n     = 1'b1;
        bus.clear_fault = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_step_out", {63'd0, bus.step_out}, 0);
        check("rst_dir_out", {63'd0, bus.dir_out}, 0);
        check("rst_drv_en_n", {63'd0, bus.drv_en_n}, 1);
        check("rst_position", int'($signed(bus.position)), 0);
        check("rst_busy", {63'd0, bus.busy}, 0);
        check("rst_flags", {62'd0, bus.step_dropped, bus.limit_hit}, 0);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.drv_enable = 1'b1;
        wait_cyc(3);

        // First + step needs a DIR change from the reset value
        step_exp(1'b1, 1'b1, HIGH_W);
        wait_cyc(480);
        check("t1_position", int'($signed(bus.position)), 1);
        check("t1_dir_out", {63'd0, bus.dir_out}, 1);
        check("t1_drv_en_n", {63'd0, bus.drv_en_n}, 0);
        check("t1_busy", {63'd0, bus.busy}, 0);

        // Ten negative steps, the first one flips DIR
        step_exp(1'b0, 1'b1, HIGH_W);
        wait_cyc(480);
        for (int i = 1; i < 10; i++) begin
            step_exp(1'b0, 1'b0, HIGH_W);
            wait_cyc(298);
        end
        check("t2_position", int'($signed(bus.position)), -9);
        check("t2_flags", {62'd0, bus.step_dropped, bus.limit_hit}, 0);

        // Steps every 50 clocks overflow the buffer: only steps 0 and 1 come out
        @(posedge clk);
        #1;
        m = cyc + 1;
        e = '{rise: m + 2, dir: 1'b0, pos: exp_pos - 1, width: HIGH_W, dirchg: 1'b0};
        sb.push_back(e);
        e = '{rise: m + 203, dir: 1'b0, pos: exp_pos - 2, width: HIGH_W, dirchg: 1'b0};
        sb.push_back(e);
        exp_pos = exp_pos - 2;
        for (int i = 0; i < 5; i++) begin
            do_step(1'b0, n);
            check("t3_step_cycle", n, m + 50 * i);
            wait_cyc(48);
        end
        wait_cyc(300);
        check("t3_step_dropped", {63'd0, bus.step_dropped}, 1);
        check("t3_position", int'($signed(bus.position)), -11);
        pulse_clear();
        @(negedge clk);
        check("t3_dropped_cleared", {63'd0, bus.step_dropped}, 0);

        // Direction flip
        step_exp(1'b1, 1'b1, HIGH_W);
        wait_cyc(480);
        check("t4_position", int'($signed(bus.position)), -10);

        // Endstop gates negative steps only
        @(posedge clk);
        #1;
        bus.limit_n = 1'b0;
        m = cyc;
        while (cyc < m + 3) wait_cyc(1);
        @(negedge clk);
`ifdef STEPDRV_HOME_ZERO_EN
        exp_pos = 0;
`endif
        check("t5_home_position", int'($signed(bus.position)), exp_pos);
        do_step(1'b0, n);
        wait_cyc(30);
        check("t5_limit_hit", {63'd0, bus.limit_hit}, 1);
        check("t5_position_held", int'($signed(bus.position)), exp_pos);
        check("t5_dir_held", {63'd0, bus.dir_out}, 1);
        check("t5_busy", {63'd0, bus.busy}, 0);
        step_exp(1'b1, 1'b0, HIGH_W);
        wait_cyc(250);
        bus.limit_n = 1'b1;
        pulse_clear();
        @(negedge clk);
        check("t5_limit_cleared", {63'd0, bus.limit_hit}, 0);
        wait_cyc(5);

        // Abort in the 40th high cycle truncates the pulse; the step stays counted
        step_exp(1'b1, 1'b0, 40);
        r = cyc + 1;
        while (cyc < r + 39) wait_cyc(1);
        bus.drv_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_abort_cycle", cyc, r + 40);
        check("t6_step_out", {63'd0, bus.step_out}, 0);
        check("t6_busy", {63'd0, bus.busy}, 0);
        check("t6_position", int'($signed(bus.position)), exp_pos);
        check("t6_drv_en_n", {63'd0, bus.drv_en_n}, 1);
        wait_cyc(5);
        do_step(1'b1, n);
        wait_cyc(10);
        check("t6_edge_ignored", {63'd0, bus.busy}, 0);
        bus.drv_enable = 1'b1;
        wait_cyc(5);
        check("t6_no_pending", {63'd0, bus.busy}, 0);
        step_exp(1'b0, 1'b1, HIGH_W);
        wait_cyc(480);
        check("final_position", int'($signed(bus.position)), exp_pos);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
